// File: rtl/utils.sv
// Shared helper functions used across the lab codebase.
package utils;

    // Number of bits needed to index 'value' entries (at least one bit).
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/voice_alloc_pkg.sv
// Shared types for the voice allocator: FSM states, stamp width default and
// the scan candidate record with its "is this one better" comparison.
package voice_alloc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ISSUE
    } alloc_state_t;

    // Default width of the allocation-order counter and per-voice stamps.
    localparam int STAMP_W_DEF = 16;

    // Widest voice index a candidate record can carry.
    localparam int IDX_W_MAX = 16;

    // A candidate found while scanning. Age is only meaningful for the steal
    // class; match/free candidates carry age 0 so the lowest index wins.
    typedef struct packed {
        logic                   valid;
        logic [IDX_W_MAX-1:0]   idx;
        logic [STAMP_W_DEF-1:0] age;
    } candidate_t;

    // A new candidate replaces the best only when strictly older, so ties
    // always stay with the lower voice index visited first.
    function automatic logic cand_better(input candidate_t cur, input candidate_t best);
        return cur.valid && (!best.valid || (cur.age > best.age));
    endfunction

endpackage

// File: rtl/voice_scan_cmp.sv
// Per-voice classifier for the allocator scan. Each SCAN cycle it classifies
// the visited voice (match / free / steal) and folds it into the registered
// best candidate of each class. The *_found/*_idx outputs already include the
// voice being visited this cycle, so the top can decide on the last SCAN cycle.
// Steal tracking exists only when VOICE_ALLOC_STEAL_EN is defined.
module voice_scan_cmp
    import voice_alloc_pkg::*;
#(
    parameter int V_WIDTH = 7
`ifdef VOICE_ALLOC_STEAL_EN
  , parameter int STAMP_W = STAMP_W_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               visit,
    input  logic [V_WIDTH-1:0] idx,
    input  logic               gated,
    input  logic               free,
    input  logic [6:0]         slot_key,
    input  logic [6:0]         note_key,
`ifdef VOICE_ALLOC_STEAL_EN
    input  logic [STAMP_W-1:0] stamp,
    input  logic [STAMP_W-1:0] alloc_cnt,
    output logic [V_WIDTH-1:0] steal_idx,
`endif
    output logic               match_found,
    output logic [V_WIDTH-1:0] match_idx,
    output logic               free_found,
    output logic [V_WIDTH-1:0] free_idx
);

    candidate_t cur_match, cur_free;
    candidate_t best_match, best_free;
    candidate_t next_match, next_free;
`ifdef VOICE_ALLOC_STEAL_EN
    candidate_t cur_steal, best_steal, next_steal;
    logic [STAMP_W-1:0] age_raw;
`endif

    // Classify the visited voice and merge it with the running best per class.
    always_comb begin
        cur_match       = '0;
        cur_match.valid = visit && gated && (slot_key == note_key);
        cur_match.idx   = IDX_W_MAX'(idx);

        cur_free        = '0;
        cur_free.valid  = visit && free && !gated;
        cur_free.idx    = IDX_W_MAX'(idx);

        next_match = cand_better(cur_match, best_match) ? cur_match : best_match;
        next_free  = cand_better(cur_free, best_free) ? cur_free : best_free;

`ifdef VOICE_ALLOC_STEAL_EN
        age_raw         = alloc_cnt - stamp;
        cur_steal       = '0;
        cur_steal.valid = visit && !(free && !gated);
        cur_steal.idx   = IDX_W_MAX'(idx);
        cur_steal.age   = STAMP_W_DEF'(age_raw);
        next_steal = cand_better(cur_steal, best_steal) ? cur_steal : best_steal;
        steal_idx  = V_WIDTH'(next_steal.idx);
`endif

        match_found = next_match.valid;
        match_idx   = V_WIDTH'(next_match.idx);
        free_found  = next_free.valid;
        free_idx    = V_WIDTH'(next_free.idx);
    end

    // Best-candidate registers: cleared at scan start, updated on each visit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_match <= '0;
            best_free  <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
            best_steal <= '0;
`endif
        end else if (start) begin
            best_match <= '0;
            best_free  <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
            best_steal <= '0;
`endif
        end else if (visit) begin
            best_match <= next_match;
            best_free  <= next_free;
`ifdef VOICE_ALLOC_STEAL_EN
            best_steal <= next_steal;
`endif
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator between midi_decoder and synth_engine. Each accepted note
// event triggers a full scan of the voice pool (one voice per cycle); the
// result is issued one cycle after the scan ends. Note-on retriggers a voice
// already holding the key, else takes the lowest free voice, else (with
// VOICE_ALLOC_STEAL_EN defined) steals the oldest voice; without the macro a
// note-on that finds no voice raises alloc_full instead. Note-off releases
// the voice holding the key or raises off_note_error.
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int VOICES  = 128,
    parameter int V_WIDTH = utils::clogb2(VOICES),
    parameter int STAMP_W = STAMP_W_DEF
) (
    input  logic               CLOCK_25,
    input  logic               reset,
    input  logic               note_req,
    input  logic               note_on_req,
    input  logic [6:0]         note_key,
    input  logic [6:0]         note_vel,
    output logic               req_ready,
    input  logic [VOICES-1:0]  voice_free,
    output logic               alloc_valid,
    output logic               alloc_gate,
    output logic [V_WIDTH-1:0] alloc_voice,
    output logic [6:0]         alloc_key,
    output logic [6:0]         alloc_vel,
    output logic               alloc_stolen,
    output logic [VOICES-1:0]  keys_on,
    output logic [V_WIDTH:0]   active_keys,
    output logic               off_note_error,
    output logic               alloc_full
);

    if (STAMP_W < 1 || STAMP_W > STAMP_W_DEF || V_WIDTH > IDX_W_MAX) begin : g_cfg_check
        $error("voice_allocator: unsupported STAMP_W or V_WIDTH");
    end

    alloc_state_t       state, state_next;
    logic [V_WIDTH-1:0] scan_idx;
    logic               accept;
    logic               last_scan;

    logic               req_on;
    logic [6:0]         req_key;
    logic [6:0]         req_vel;
    logic [6:0]         slot_key [VOICES];

    logic               match_found;
    logic [V_WIDTH-1:0] match_idx;
    logic               free_found;
    logic [V_WIDTH-1:0] free_idx;

    logic               do_valid;
    logic               do_gate;
    logic               do_err;
    logic [V_WIDTH-1:0] target;
    logic [V_WIDTH:0]   key_count;

`ifdef VOICE_ALLOC_STEAL_EN
    logic [STAMP_W-1:0] stamp [VOICES];
    logic [STAMP_W-1:0] alloc_cnt;
    logic [V_WIDTH-1:0] steal_idx;
    logic               do_stolen;
`else
    logic               do_full;
`endif

    assign accept    = (state == IDLE) && note_req;
    assign last_scan = (state == SCAN) && (scan_idx == V_WIDTH'(VOICES - 1));

    voice_scan_cmp #(
        .V_WIDTH   (V_WIDTH)
`ifdef VOICE_ALLOC_STEAL_EN
      , .STAMP_W   (STAMP_W)
`endif
    ) u_scan (
        .clk         (CLOCK_25),
        .rst         (reset),
        .start       (accept),
        .visit       (state == SCAN),
        .idx         (scan_idx),
        .gated       (keys_on[scan_idx]),
        .free        (voice_free[scan_idx]),
        .slot_key    (slot_key[scan_idx]),
        .note_key    (req_key),
`ifdef VOICE_ALLOC_STEAL_EN
        .stamp       (stamp[scan_idx]),
        .alloc_cnt   (alloc_cnt),
        .steal_idx   (steal_idx),
`endif
        .match_found (match_found),
        .match_idx   (match_idx),
        .free_found  (free_found),
        .free_idx    (free_idx)
    );

    // State register.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; requests are only taken (and req_ready high) in IDLE.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (note_req) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (last_scan) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the request at acceptance and step the scan index through the pool.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            req_on   <= 1'b0;
            req_key  <= '0;
            req_vel  <= '0;
            scan_idx <= '0;
        end else if (accept) begin
            req_on   <= note_on_req;
            req_key  <= note_key;
            req_vel  <= note_vel;
            scan_idx <= '0;
        end else if (state == SCAN) begin
            scan_idx <= last_scan ? '0 : scan_idx + 1'b1;
        end
    end

    // Final decision on the last scan cycle using candidates that include it.
    always_comb begin
        do_valid = 1'b0;
        do_gate  = 1'b0;
        do_err   = 1'b0;
        target   = '0;
`ifdef VOICE_ALLOC_STEAL_EN
        do_stolen = 1'b0;
`else
        do_full   = 1'b0;
`endif
        if (last_scan) begin
            if (req_on) begin
                if (match_found) begin
                    do_valid = 1'b1;
                    do_gate  = 1'b1;
                    target   = match_idx;
                end else if (free_found) begin
                    do_valid = 1'b1;
                    do_gate  = 1'b1;
                    target   = free_idx;
                end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                    do_valid  = 1'b1;
                    do_gate   = 1'b1;
                    do_stolen = 1'b1;
                    target    = steal_idx;
`else
                    do_full   = 1'b1;
`endif
                end
            end else if (match_found) begin
                do_valid = 1'b1;
                target   = match_idx;
            end else begin
                do_err = 1'b1;
            end
        end
    end

    // Result outputs: strobes live for the ISSUE cycle, fields hold between events.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            alloc_valid    <= 1'b0;
            off_note_error <= 1'b0;
            alloc_gate     <= 1'b0;
            alloc_voice    <= '0;
            alloc_key      <= '0;
            alloc_vel      <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
            alloc_stolen   <= 1'b0;
`else
            alloc_full     <= 1'b0;
`endif
        end else begin
            alloc_valid    <= do_valid;
            off_note_error <= do_err;
`ifndef VOICE_ALLOC_STEAL_EN
            alloc_full     <= do_full;
`endif
            if (do_valid) begin
                alloc_gate  <= do_gate;
                alloc_voice <= target;
                alloc_key   <= req_key;
                alloc_vel   <= req_vel;
`ifdef VOICE_ALLOC_STEAL_EN
                alloc_stolen <= do_stolen;
`endif
            end
        end
    end

`ifdef VOICE_ALLOC_STEAL_EN
    assign alloc_full = 1'b0;
`else
    assign alloc_stolen = 1'b0;
`endif

    // Per-voice gate, key slot and allocation stamp, updated when a result issues.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            keys_on <= '0;
            for (int i = 0; i < VOICES; i++) begin
                slot_key[i] <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
                stamp[i]    <= '0;
`endif
            end
`ifdef VOICE_ALLOC_STEAL_EN
            alloc_cnt <= '0;
`endif
        end else if (do_valid) begin
            if (do_gate) begin
                keys_on[target]  <= 1'b1;
                slot_key[target] <= req_key;
`ifdef VOICE_ALLOC_STEAL_EN
                stamp[target]    <= alloc_cnt;
                alloc_cnt        <= alloc_cnt + 1'b1;
`endif
            end else begin
                keys_on[target] <= 1'b0;
            end
        end
    end

    // Population count of the gate bitmap.
    always_comb begin
        key_count = '0;
        for (int i = 0; i < VOICES; i++) begin
            key_count = key_count + (V_WIDTH + 1)'(keys_on[i]);
        end
    end

    // Registered active key count, one cycle behind keys_on.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            active_keys <= '0;
        end else begin
            active_keys <= key_count;
        end
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules the shared voice pool of synth_engine between incoming MIDI note events.
- Sits between midi_decoder and synth_engine.
- Note-on is assigned to a retriggered, free, or stolen (oldest) voice. Note-off releases the voice holding that key.
- Owns the keys_on gate bitmap and the active_keys count.

Parameters:
- VOICES, 128, number of voices in the pool.
- V_WIDTH, utils::clogb2(VOICES), voice index width.
- STAMP_W, 16, width of the allocation-order counter and per-voice stamps.

Ports:
- CLOCK_25  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- note_req  in  1  one-cycle request strobe; accepted only while req_ready=1.
- note_on_req  in  1  1=note-on, 0=note-off.
- note_key  in  7  MIDI key number.
- note_vel  in  7  velocity.
- req_ready  out  V=1  high only in IDLE.
- voice_free  in  VOICES  per-voice envelope-finished flags from envelope generator.
- alloc_valid  out  1  one-cycle result strobe.
- alloc_gate  out  1  1=gate on, 0=gate off.
- alloc_voice  out  V_WIDTH  target voice.
- alloc_key  out  7  key of event.
- alloc_vel  out  7  velocity of event.
- alloc_stolen  out  1  qualifies alloc_valid: voice was stolen.
- keys_on  out  VOICES  gate bitmap.
- active_keys  out  V_WIDTH+1  popcount of keys_on.
- off_note_error  out  1  one-cycle pulse: note-off matched no gated voice.
- alloc_full  out  1  one-cycle pulse: note-on dropped (see Optional Feature).

Behaviour:
- Reset (async, active-high): state IDLE. keys_on=0, active_keys=0, all stamps and key slots=0, alloc counter=0. All strobes and alloc_* outputs=0. req_ready=1 after release. Reset mid-scan abandons the event with no output.
- States: IDLE -> SCAN (note_req accepted, inputs latched) -> ISSUE -> IDLE.
- SCAN visits voice i=0..VOICES-1, one per cycle, always the full VOICES cycles.
- Latency: request at cycle 0; alloc_valid, off_note_error or alloc_full at cycle VOICES+1; req_ready high again at cycle VOICES+2.
- Note-on candidates, tracked in SCAN:
  - match: keys_on[i] && key[i]==note_key.
  - free: voice_free[i] && !keys_on[i].
  - steal: any non-free voice; age = (alloc_cnt - stamp[i]) mod 2^STAMP_W, largest age wins.
  - Ties in every class go to the lowest index.
- Note-on priority in ISSUE: match (retrigger, alloc_stolen=0) > free > steal (alloc_stolen=1).
- Note-on ISSUE updates:
  - keys_on[v]=1, key[v]=note_key, stamp[v]=alloc_cnt.
  - alloc_cnt++, wrapping modulo 2^STAMP_W.
  - alloc_gate=1, alloc_valid=1.
- Note-off: first voice with match. If found: keys_on[v]=0 and alloc_valid with alloc_gate=0, alloc_vel=note_vel. If none: off_note_error pulse and no alloc_valid.
- voice_free is sampled live during SCAN. A change to voice i after it has been visited is ignored for this event.
- alloc_* fields hold their last values between strobes. active_keys is registered and updates the cycle after ISSUE.
- note_req while req_ready=0 is ignored (not queued).

Optional Feature:
- Macro: VOICE_ALLOC_STEAL_EN.
- Defined: steal class enabled as above. A note-on always produces alloc_valid. alloc_full is tied to 0.
- Undefined: no steal tracking and no stamp arithmetic. A note-on with no match and no free voice produces an alloc_full pulse in ISSUE, no alloc_valid, and no state change. alloc_stolen is tied to 0.

Decomposition:
- Package voice_alloc_pkg holds:
  - alloc_state_t enum {IDLE, SCAN, ISSUE}.
  - STAMP_W default constant.
  - candidate struct {valid, idx, age}.
- clogb2 comes from the existing utils package.
- One sub-module, voice_scan_cmp: combinational per-voice classifier plus registered best-candidate update (match/free/steal). It is reset by a start pulse at SCAN entry.

Test Plan:
- VOICES=8, all voice_free=1; note-on key 60 vel 100 -> alloc_valid at cycle 9, voice 0, gate 1, stolen 0; keys_on=8'h01; active_keys=1 one cycle later.
- Note-on 60, then note-on 60 again -> second event retriggers voice 0 (not voice 1), alloc_stolen=0, active_keys stays 1.
- Note-on keys 60..67 filling all 8 voices, voice_free=0, then note-on 70:
  - with STEAL_EN: voice 0 (oldest), alloc_stolen=1, keys_on still 8'hFF.
  - without STEAL_EN: alloc_full pulse, no alloc_valid.
- Note-off 61 with 61 on voice 1 -> alloc_valid, gate 0, voice 1, keys_on bit1 cleared. Note-off 99 (not held) -> off_note_error pulse only.
- STAMP_W=3, 10 on/off cycles to wrap alloc_cnt, then fill and steal -> oldest-by-modular-age voice chosen.
- Assert reset at SCAN cycle 4 -> no strobe; keys_on=0; req_ready=1 after release; next note-on gets voice 0.
